// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline.
// Merges stage stall requests and serialises PC redirects into one-cycle pulses.
module pipe_ctrl #(
    parameter int PC_W        = 64,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall_req,
    input  logic             id_stall_req,
    input  logic             ex_stall_req,
    input  logic             mem_stall_req,
    input  logic             id_redir_req,
    input  logic [PC_W-1:0]  id_redir_pc,
    input  logic             ex_redir_req,
    input  logic [PC_W-1:0]  ex_redir_pc,
    input  logic             trap_req,
    input  logic [PC_W-1:0]  trap_pc,
    input  logic             cnt_clr,
    output logic [4:0]       stall,
    output logic [3:0]       bubble,
    output logic             redir_ena,
    output logic [PC_W-1:0]  redir_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wdog_err
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      pri_q, pri_nxt, req_pri;
    logic [PC_W-1:0] pc_q, pc_nxt, req_pc;
    logic [4:0]      merge_stall, stall_raw;
    logic [3:0]      merge_bub, kill, bub_raw;
    logic            take, gate;
    logic [WD_W-1:0] wd_cnt;

    always_comb begin
        req_pri = 2'd0;
        req_pc  = id_redir_pc;
        if (trap_req) begin
            req_pri = 2'd3;
            req_pc  = trap_pc;
        end else if (ex_redir_req) begin
            req_pri = 2'd2;
            req_pc  = ex_redir_pc;
        end else if (id_redir_req) begin
            req_pri = 2'd1;
        end
    end

    always_comb begin
        merge_stall = 5'b00000;
        merge_bub   = 4'b0000;
        if (mem_stall_req) begin
            merge_stall = 5'b01111;
            merge_bub   = 4'b1000;
        end else if (ex_stall_req) begin
            merge_stall = 5'b00111;
            merge_bub   = 4'b0100;
        end else if (id_stall_req) begin
            merge_stall = 5'b00011;
            merge_bub   = 4'b0010;
        end else if (if_stall_req) begin
            merge_stall = 5'b00001;
            merge_bub   = 4'b0001;
        end
    end

    // Younger stages behind the redirecting one are flushed on the request cycle.
    always_comb begin
        kill = 4'b0000;
        case (req_pri)
            2'd3:    kill = 4'b0111;
            2'd2:    kill = 4'b0011;
            2'd1:    kill = 4'b0001;
            default: kill = 4'b0000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pri_nxt   = pri_q;
        pc_nxt    = pc_q;
        take      = (state == IDLE) ? (req_pri != 2'd0) : (req_pri > pri_q);
        if (take) begin
            pri_nxt = req_pri;
            pc_nxt  = req_pc;
        end
        gate = (pri_nxt == 2'd3) ? !mem_stall_req
                                 : (!if_stall_req && !mem_stall_req);
        case (state)
            IDLE:    if (take) state_nxt = gate ? ISSUE : WAIT;
            WAIT:    state_nxt = gate ? ISSUE : WAIT;
            ISSUE:   state_nxt = take ? (gate ? ISSUE : WAIT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pri_q <= 2'd0;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            pri_q <= pri_nxt;
            pc_q  <= pc_nxt;
        end
    end

    assign stall_raw = merge_stall | {4'b0000, state == WAIT};
    assign bub_raw   = merge_bub | kill | {3'b000, state != IDLE};

    // A held register must not also be loaded with a NOP.
    assign stall     = rst ? stall_raw : 5'b00000;
    assign bubble    = rst ? (bub_raw & ~stall_raw[4:1]) : 4'b0000;
    assign redir_ena = (state == ISSUE);
    assign redir_pc  = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_raw[0] && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
        end else if (state == WAIT) begin
            if (wd_cnt != WD_W'(WDOG_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) wdog_err <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a pending/pulse reference model of the redirect rules.
module tb_pipe_ctrl;

    localparam int PC_W  = 64;
    localparam int CNT_W = 4;
    localparam int WD    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
    logic             id_redir_req, ex_redir_req, trap_req, cnt_clr;
    logic [PC_W-1:0]  id_redir_pc, ex_redir_pc, trap_pc;
    logic [4:0]       stall;
    logic [3:0]       bubble;
    logic             redir_ena;
    logic [PC_W-1:0]  redir_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             wdog_err;

    pipe_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst),
        .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
        .id_redir_req(id_redir_req), .id_redir_pc(id_redir_pc),
        .ex_redir_req(ex_redir_req), .ex_redir_pc(ex_redir_pc),
        .trap_req(trap_req), .trap_pc(trap_pc), .cnt_clr(cnt_clr),
        .stall(stall), .bubble(bubble), .redir_ena(redir_ena),
        .redir_pc(redir_pc), .stall_cnt(stall_cnt), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a redirect is either pending (held back) or pulsing.
    bit              m_pend, m_pulse, m_err;
    int              m_pri, m_cnt, m_run;
    logic [PC_W-1:0] m_pc;
    logic [4:0]      e_stall;
    logic [3:0]      e_bubble;

    function automatic int req_pri();
        return trap_req ? 3 : ex_redir_req ? 2 : id_redir_req ? 1 : 0;
    endfunction

    function automatic bit gate_open(int p);
        return (p == 3) ? !mem_stall_req : (!if_stall_req && !mem_stall_req);
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pulse = 0; m_err = 0;
        m_pri = 0; m_cnt = 0; m_run = 0; m_pc = '0;
    endtask

    task automatic model_comb();
        int s, b, k;
        s = mem_stall_req ? 15 : ex_stall_req ? 7 : id_stall_req ? 3 : if_stall_req ? 1 : 0;
        if (m_pend) s = s | 1;
        b = mem_stall_req ? 8 : ex_stall_req ? 4 : id_stall_req ? 2 : if_stall_req ? 1 : 0;
        k = req_pri();
        b = b | ((k == 3) ? 7 : (k == 2) ? 3 : (k == 1) ? 1 : 0);
        if (m_pend || m_pulse) b = b | 1;
        b = b & ~(s >> 1);
        e_stall  = s[4:0];
        e_bubble = b[3:0];
    endtask

    task automatic model_tick();
        int p;
        bit take;
        p = req_pri();
        take = (m_pend || m_pulse) ? (p > m_pri) : (p > 0);
        if (cnt_clr) m_cnt = 0;
        else if (e_stall[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_pend) begin
            m_run++;
            if (m_run >= WD) m_err = 1;
        end else m_run = 0;
        if (take) begin
            m_pri = p;
            m_pc  = (p == 3) ? trap_pc : (p == 2) ? ex_redir_pc : id_redir_pc;
        end
        if (take || m_pend) begin
            if (gate_open(m_pri)) begin m_pulse = 1; m_pend = 0; end
            else begin m_pulse = 0; m_pend = 1; end
        end else begin
            m_pulse = 0; m_pend = 0;
        end
    endtask

    task automatic idle_in();
        if_stall_req = 0; id_stall_req = 0; ex_stall_req = 0; mem_stall_req = 0;
        id_redir_req = 0; ex_redir_req = 0; trap_req = 0; cnt_clr = 0;
        id_redir_pc = '0; ex_redir_pc = '0; trap_pc = '0;
    endtask

    task automatic settle();
        #2;
        model_comb();
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 0;
        mem_stall_req = 1; trap_req = 1; trap_pc = 64'h55;
        #1;
        n_tests++;
        if (stall !== 5'b0 || bubble !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_comb stall=%b bubble=%b required 0/0", stall, bubble);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (redir_ena !== 1'b0 || redir_pc !== '0 || stall_cnt !== '0 || wdog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs ena=%b pc=%h cnt=%0d wdog=%b required 0", redir_ena, redir_pc, stall_cnt, wdog_err);
        end
        do_reset();
    endtask

    task automatic test_stall_merge();
        logic [4:0] ts [4];
        logic [3:0] tb [4];
        do_reset();
        mem_stall_req = 1; id_stall_req = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_tests++;
            if (stall !== 5'b01111 || bubble !== 4'b1000) begin
                n_fail++;
                $display("FAIL merge_mem cyc%0d stall=%b bubble=%b required 01111/1000", i, stall, bubble);
            end
            tick();
        end
        idle_in();
        settle();
        n_tests++;
        if (stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL merge_cnt stall_cnt=%0d required 3", stall_cnt);
        end
        ts[0] = 5'b00111; tb[0] = 4'b0100;
        ts[1] = 5'b00011; tb[1] = 4'b0010;
        ts[2] = 5'b00001; tb[2] = 4'b0001;
        ts[3] = 5'b00000; tb[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            idle_in();
            ex_stall_req = (i == 0);
            id_stall_req = (i <= 1);
            if_stall_req = (i <= 2);
            settle();
            n_tests++;
            if (stall !== ts[i] || bubble !== tb[i]) begin
                n_fail++;
                $display("FAIL merge_tab%0d stall=%b bubble=%b required %b/%b", i, stall, bubble, ts[i], tb[i]);
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_ex_redirect();
        do_reset();
        ex_redir_req = 1; ex_redir_pc = 64'h8000_0040;
        settle();
        n_tests++;
        if (bubble !== 4'b0011 || redir_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL ex_req bubble=%b ena=%b required 0011/0", bubble, redir_ena);
        end
        tick();
        idle_in();
        settle();
        n_tests++;
        if (redir_ena !== 1'b1 || redir_pc !== 64'h8000_0040) begin
            n_fail++;
            $display("FAIL ex_issue ena=%b pc=%h required 1/80000040", redir_ena, redir_pc);
        end
        tick();
        settle();
        n_tests++;
        if (redir_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL ex_after ena=%b required 0", redir_ena);
        end
        tick();
    endtask

    task automatic test_wait_overwrite();
        int pulses;
        logic [PC_W-1:0] seen;
        pulses = 0;
        seen = '0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle_in();
            if_stall_req = (c < 4);
            id_redir_req = (c == 0); id_redir_pc = 64'h200;
            trap_req = (c == 2); trap_pc = 64'h100;
            settle();
            if (c == 1) begin
                n_tests++;
                if (stall[0] !== 1'b1 || bubble[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wait_hold stall=%b bubble=%b required stall[0]=1 bubble[0]=1", stall, bubble);
                end
            end
            if (redir_ena === 1'b1) begin
                pulses++;
                seen = redir_pc;
            end
            tick();
        end
        n_tests++;
        if (pulses != 1 || seen !== 64'h100) begin
            n_fail++;
            $display("FAIL wait_overwrite pulses=%0d pc=%h required 1/100", pulses, seen);
        end
        idle_in();
    endtask

    task automatic test_issue_recapture();
        do_reset();
        ex_redir_req = 1; ex_redir_pc = 64'hA0;
        tick();
        idle_in();
        trap_req = 1; trap_pc = 64'hB0;
        settle();
        n_tests++;
        if (redir_ena !== 1'b1 || redir_pc !== 64'hA0) begin
            n_fail++;
            $display("FAIL recap_first ena=%b pc=%h required 1/a0", redir_ena, redir_pc);
        end
        tick();
        idle_in();
        settle();
        n_tests++;
        if (redir_ena !== 1'b1 || redir_pc !== 64'hB0) begin
            n_fail++;
            $display("FAIL recap_second ena=%b pc=%h required 1/b0", redir_ena, redir_pc);
        end
        tick();
        trap_req = 1; trap_pc = 64'hC0;
        tick();
        idle_in();
        ex_redir_req = 1; ex_redir_pc = 64'hD0;
        settle();
        n_tests++;
        if (redir_ena !== 1'b1 || redir_pc !== 64'hC0) begin
            n_fail++;
            $display("FAIL drop_first ena=%b pc=%h required 1/c0", redir_ena, redir_pc);
        end
        tick();
        idle_in();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_tests++;
            if (redir_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_lower cyc%0d ena=%b required 0", i, redir_ena);
            end
            tick();
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        if_stall_req = 1;
        id_redir_req = 1; id_redir_pc = 64'h44;
        tick();
        id_redir_req = 0;
        for (int k = 1; k <= WD; k++) begin
            settle();
            n_tests++;
            if (wdog_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_early wait%0d err=%b required 0", k, wdog_err);
            end
            tick();
        end
        settle();
        n_tests++;
        if (wdog_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_set err=%b required 1", wdog_err);
        end
        idle_in();
        repeat (3) tick();
        settle();
        n_tests++;
        if (wdog_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_sticky err=%b required 1", wdog_err);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        do_reset();
        if_stall_req = 1;
        id_redir_req = 1; id_redir_pc = 64'h77;
        tick();
        id_redir_req = 0;
        tick();
        #2;
        rst = 0;
        #1;
        n_tests++;
        if (stall !== 5'b0 || bubble !== 4'b0 || redir_ena !== 1'b0 || redir_pc !== '0
            || stall_cnt !== '0 || wdog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst stall=%b bub=%b ena=%b pc=%h cnt=%0d wdog=%b required all 0",
                     stall, bubble, redir_ena, redir_pc, stall_cnt, wdog_err);
        end
        @(posedge clk);
        #3;
        rst = 1;
        model_reset();
        idle_in();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (redir_ena === 1'b1) pulses++;
            tick();
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL async_drop pulses=%0d required 0", pulses);
        end
        mem_stall_req = 1;
        repeat (2) tick();
        cnt_clr = 1;
        tick();
        idle_in();
        settle();
        n_tests++;
        if (stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL cnt_clr stall_cnt=%0d required 0", stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if_stall_req  = ($urandom_range(99) < 30);
            id_stall_req  = ($urandom_range(99) < 10);
            ex_stall_req  = ($urandom_range(99) < 10);
            mem_stall_req = ($urandom_range(99) < 10);
            id_redir_req  = ($urandom_range(99) < 10);
            ex_redir_req  = ($urandom_range(99) < 8);
            trap_req      = ($urandom_range(99) < 5);
            cnt_clr       = ($urandom_range(99) < 3);
            id_redir_pc   = {$urandom, $urandom};
            ex_redir_pc   = {$urandom, $urandom};
            trap_pc       = {$urandom, $urandom};
            settle();
            n_tests++;
            if (stall !== e_stall || bubble !== e_bubble) begin
                n_fail++;
                $display("FAIL rnd_comb cyc%0d stall=%b bubble=%b required %b/%b", c, stall, bubble, e_stall, e_bubble);
            end
            n_tests++;
            if (redir_ena !== m_pulse || (m_pulse && redir_pc !== m_pc)) begin
                n_fail++;
                $display("FAIL rnd_redir cyc%0d ena=%b pc=%h required %b/%h", c, redir_ena, redir_pc, m_pulse, m_pc);
            end
            n_tests++;
            if (stall_cnt !== m_cnt[CNT_W-1:0] || wdog_err !== m_err) begin
                n_fail++;
                $display("FAIL rnd_cnt cyc%0d cnt=%0d wdog=%b required %0d/%b", c, stall_cnt, wdog_err, m_cnt, m_err);
            end
            tick();
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 0;
        model_reset();
        test_reset();
        test_stall_merge();
        test_ex_redirect();
        test_wait_overwrite();
        test_issue_recapture();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
